// File: rtl/skinny_sbox_layer_seq.sv
// Sequences one 3-share Skinny-64 S-box layer through a single shared HPC2 S-box,
// one nibble per evaluation, with per-evaluation fresh randomness and a Synch timeout.
module skinny_sbox_layer_seq #(
   parameter int unsigned NIBBLES = 16,
   parameter int unsigned FRESH_W = 51,
   parameter int unsigned TIMEOUT = 31
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] in_s0,
   input  logic [4*NIBBLES-1:0] in_s1,
   input  logic [4*NIBBLES-1:0] in_s2,
   input  logic [FRESH_W-1:0]   fresh_i,
   input  logic                 fresh_valid,
   output logic                 fresh_ready,
   output logic [3:0]           sb_x_s0,
   output logic [3:0]           sb_x_s1,
   output logic [3:0]           sb_x_s2,
   output logic [FRESH_W-1:0]   sb_fresh,
   output logic                 sb_rst,
   input  logic [3:0]           sb_y_s0,
   input  logic [3:0]           sb_y_s1,
   input  logic [3:0]           sb_y_s2,
   input  logic                 sb_synch,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] out_s0,
   output logic [4*NIBBLES-1:0] out_s1,
   output logic [4*NIBBLES-1:0] out_s2,
   output logic                 err
);

   localparam int unsigned W     = 4 * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_KICK,
      S_WAIT,
      S_DONE
   } state_t;

   state_t             state, state_nxt;
   logic [W-1:0]       buf_s0, buf_s1, buf_s2;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W+1:0]   nib_lo;
   logic [CNT_W-1:0]   wait_cnt;
   logic [FRESH_W-1:0] fresh_q;
   logic [3:0]         x_s0, x_s1, x_s2;
   logic               err_q;
   logic               last_nib;
   logic               wait_expired;

   assign nib_lo       = {idx, 2'b00};
   assign last_nib     = (idx == IDX_W'(NIBBLES - 1));
   assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt   = state;
      in_ready    = 1'b0;
      fresh_ready = 1'b0;
      out_valid   = 1'b0;
      sb_rst      = 1'b1;
      sb_fresh    = '0;
      out_s0      = '0;
      out_s1      = '0;
      out_s2      = '0;
      case (state)
         S_IDLE: begin
            in_ready = rst;
            if (in_valid) state_nxt = S_LOAD;
         end
         S_LOAD: begin
            fresh_ready = fresh_valid;
            if (fresh_valid) state_nxt = S_KICK;
         end
         S_KICK: begin
            sb_fresh  = fresh_q;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            sb_rst   = 1'b0;
            sb_fresh = fresh_q;
            // Synch on the final allowed cycle wins over the timeout
            if (sb_synch)          state_nxt = last_nib ? S_DONE : S_LOAD;
            else if (wait_expired) state_nxt = S_IDLE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            out_s0    = buf_s0;
            out_s1    = buf_s1;
            out_s2    = buf_s2;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= S_IDLE;
         idx      <= '0;
         wait_cnt <= '0;
         buf_s0   <= '0;
         buf_s1   <= '0;
         buf_s2   <= '0;
         fresh_q  <= '0;
         x_s0     <= '0;
         x_s1     <= '0;
         x_s2     <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: if (in_valid) begin
               buf_s0 <= in_s0;
               buf_s1 <= in_s1;
               buf_s2 <= in_s2;
               idx    <= '0;
               err_q  <= 1'b0;
            end
            S_LOAD: if (fresh_valid) begin
               fresh_q <= fresh_i;
               x_s0    <= buf_s0[nib_lo +: 4];
               x_s1    <= buf_s1[nib_lo +: 4];
               x_s2    <= buf_s2[nib_lo +: 4];
            end
            S_KICK: wait_cnt <= '0;
            S_WAIT: begin
               if (sb_synch) begin
                  buf_s0[nib_lo +: 4] <= sb_y_s0;
                  buf_s1[nib_lo +: 4] <= sb_y_s1;
                  buf_s2[nib_lo +: 4] <= sb_y_s2;
                  x_s0 <= '0;
                  x_s1 <= '0;
                  x_s2 <= '0;
                  if (!last_nib) idx <= idx + IDX_W'(1);
               end else if (wait_expired) begin
                  err_q  <= 1'b1;
                  buf_s0 <= '0;
                  buf_s1 <= '0;
                  buf_s2 <= '0;
                  x_s0   <= '0;
                  x_s1   <= '0;
                  x_s2   <= '0;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end
            S_DONE: if (out_ready) begin
               buf_s0  <= '0;
               buf_s1  <= '0;
               buf_s2  <= '0;
               fresh_q <= '0;
            end
            default: ;
         endcase
      end
   end

   assign sb_x_s0 = x_s0;
   assign sb_x_s1 = x_s1;
   assign sb_x_s2 = x_s2;
   assign err     = err_q;

endmodule

// File: tb/tb_skinny_sbox_layer_seq.sv
// Scoreboard bench for skinny_sbox_layer_seq with a behavioural 3-share S-box that
// raises Synch a programmable number of cycles after its reset drops.
module tb_skinny_sbox_layer_seq;

   localparam int FW = 51;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [63:0]   in_s0 = '0, in_s1 = '0, in_s2 = '0;
   logic [FW-1:0] fresh_i = '0;
   logic          fresh_valid = 1'b1;
   logic          fresh_ready;
   logic [3:0]    sb_x_s0, sb_x_s1, sb_x_s2;
   logic [FW-1:0] sb_fresh;
   logic          sb_rst;
   logic [3:0]    sb_y_s0, sb_y_s1, sb_y_s2;
   logic          sb_synch;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [63:0]   out_s0, out_s1, out_s2;
   logic          err;

   skinny_sbox_layer_seq #(.NIBBLES(16), .FRESH_W(FW), .TIMEOUT(31)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_s0(in_s0), .in_s1(in_s1), .in_s2(in_s2),
      .fresh_i(fresh_i), .fresh_valid(fresh_valid), .fresh_ready(fresh_ready),
      .sb_x_s0(sb_x_s0), .sb_x_s1(sb_x_s1), .sb_x_s2(sb_x_s2),
      .sb_fresh(sb_fresh), .sb_rst(sb_rst),
      .sb_y_s0(sb_y_s0), .sb_y_s1(sb_y_s1), .sb_y_s2(sb_y_s2),
      .sb_synch(sb_synch),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s0(out_s0), .out_s1(out_s1), .out_s2(out_s2),
      .err(err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          hs_cyc = 0;
   int          fr_cnt = 0;
   logic [63:0] sb_q[$];
   logic [63:0] last_out = '0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] sbox(input logic [3:0] x);
      case (x)
         4'h0: return 4'hC; 4'h1: return 4'h6; 4'h2: return 4'h9; 4'h3: return 4'h0;
         4'h4: return 4'h1; 4'h5: return 4'hA; 4'h6: return 4'h2; 4'h7: return 4'hB;
         4'h8: return 4'h3; 4'h9: return 4'h8; 4'hA: return 4'h5; 4'hB: return 4'hD;
         4'hC: return 4'h4; 4'hD: return 4'hE; 4'hE: return 4'h7; default: return 4'hF;
      endcase
   endfunction

   function automatic logic [63:0] sbox_layer(input logic [63:0] d);
      logic [63:0] r;
      for (int i = 0; i < 16; i++) r[4*i +: 4] = sbox(d[4*i +: 4]);
      return r;
   endfunction

   // S-box model: fresh output masks per evaluation, Synch on WAIT cycle sb_lat
   int unsigned sb_lat = 9;
   bit          synch_en = 1'b1;
   bit          junk_synch = 1'b0;
   int unsigned wcnt = 0;
   logic [3:0]  m0 = '0, m1 = '0;

   always @(posedge clk) begin
      if (sb_rst) begin
         wcnt <= 0;
         m0   <= 4'($urandom);
         m1   <= 4'($urandom);
      end else begin
         wcnt <= wcnt + 1;
      end
   end

   assign sb_synch = synch_en && (sb_rst ? junk_synch : (wcnt == sb_lat - 1));
   assign sb_y_s0  = m0;
   assign sb_y_s1  = m1;
   assign sb_y_s2  = sbox(sb_x_s0 ^ sb_x_s1 ^ sb_x_s2) ^ m0 ^ m1;

   always @(posedge clk) cyc <= cyc + 1;

   // Output scoreboard and fresh-forwarding monitor
   bit            fr_pend = 1'b0;
   logic [FW-1:0] fr_val = '0;

   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         last_out = out_s0 ^ out_s1 ^ out_s2;
         if (sb_q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
         else                  check("layer_result", last_out, sb_q.pop_front());
      end
      if (rst && fr_pend) check("fresh_fwd", {12'd0, sb_rst, sb_fresh}, {12'd0, 1'b1, fr_val});
      fr_pend = rst && fresh_ready;
      fr_val  = fresh_i;
      if (rst && fresh_ready) fr_cnt <= fr_cnt + 1;
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 fresh_i = {$urandom, $urandom};
      end
   end

   task automatic send(input logic [63:0] d, input bit push, input bit zero_mask);
      logic [63:0] a, b;
      int n;
      a = zero_mask ? 64'd0 : {$urandom, $urandom};
      b = zero_mask ? 64'd0 : {$urandom, $urandom};
      @(posedge clk);
      #1;
      in_s0 = a; in_s1 = b; in_s2 = d ^ a ^ b; in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 1000);
      if (!in_ready) begin
         check("in_handshake", 64'd0, 64'd1);
         in_valid = 1'b0;
      end else begin
         if (push) sb_q.push_back(sbox_layer(d));
         @(posedge clk);
         #1;
         hs_cyc = cyc;
         in_valid = 1'b0;
         in_s0 = '0; in_s1 = '0; in_s2 = '0;
      end
   endtask

   task automatic wait_out(input int budget, output int lat);
      int  n;
      bit  seen;
      n = 0; seen = 1'b0; lat = -1;
      while (!seen && n < budget) begin
         @(negedge clk);
         n++;
         if (out_valid) begin
            seen = 1'b1;
            lat  = cyc - hs_cyc;
         end
      end
      if (!seen) check("out_valid_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, base;
      logic [63:0] d, snap0, snap1, snap2;

      // Reset state, with in_valid and fresh_valid asserted to prove they are masked
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {59'd0, in_ready, out_valid, fresh_ready, err, sb_rst}, 64'b00001);
      check("rst_sbox", {1'b0, sb_x_s0, sb_x_s1, sb_x_s2, sb_fresh}, 64'd0);
      check("rst_out", out_s0 | out_s1 | out_s2, 64'd0);
      in_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      check("idle_ready", {63'd0, in_ready}, 64'd1);

      // All-zero shares, Synch on 9th WAIT cycle
      send(64'd0, 1'b1, 1'b1);
      wait_out(400, lat);
      check("t1_latency", 64'(lat), 64'd176);
      @(posedge clk); #1;
      check("t1_value", last_out, 64'hCCCC_CCCC_CCCC_CCCC);

      // Fixed plaintext under two maskings; second run also floods Synch outside WAIT
      for (int r = 0; r < 2; r++) begin
         junk_synch = (r == 1);
         send(64'h0123_4567_89AB_CDEF, 1'b1, 1'b0);
         wait_out(400, lat);
         check("t2_latency", 64'(lat), 64'd176);
         @(posedge clk); #1;
         check("t2_value", last_out, 64'hC690_1A2B_385D_4E7F);
      end
      junk_synch = 1'b0;

      // Synch on first WAIT cycle, and on the last cycle before timeout
      sb_lat = 1;
      send({$urandom, $urandom}, 1'b1, 1'b0);
      wait_out(400, lat);
      check("lat1_latency", 64'(lat), 64'd48);
      sb_lat = 31;
      send({$urandom, $urandom}, 1'b1, 1'b0);
      wait_out(1000, lat);
      check("lat31_latency", 64'(lat), 64'd528);
      check("lat31_no_err", {63'd0, err}, 64'd0);
      sb_lat = 9;

      // Fresh randomness stall at nibble 7
      @(posedge clk); #1;
      base = fr_cnt;
      fork
         begin
            send({$urandom, $urandom}, 1'b1, 1'b0);
            wait_out(600, lat);
         end
         begin
            n = 0;
            while (n < 7) begin
               @(negedge clk);
               if (fresh_ready) n++;
            end
            @(posedge clk);
            #1 fresh_valid = 1'b0;
            for (int i = 0; i < 15; i++) begin
               @(posedge clk);
               if (i >= 9 && i <= 13) begin
                  @(negedge clk);
                  check("t3_stall", {61'd0, fresh_ready, ~sb_rst, |{sb_x_s0, sb_x_s1, sb_x_s2, sb_fresh}}, 64'd0);
               end
            end
            #1 fresh_valid = 1'b1;
         end
      join
      check("t3_latency", 64'(lat), 64'd181);
      @(posedge clk); #1;
      check("t3_fresh_pulses", 64'(fr_cnt - base), 64'd16);

      // Synch never arrives: timeout, err sticky until next accepted input
      synch_en = 1'b0;
      send({$urandom, $urandom}, 1'b0, 1'b0);
      n = 0;
      while (!err && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("t4_err", {63'd0, err}, 64'd1);
      check("t4_err_latency", 64'(cyc - hs_cyc), 64'd33);
      check("t4_idle", {61'd0, in_ready, sb_rst, out_valid}, 64'b110);
      repeat (5) @(negedge clk);
      check("t4_err_sticky", {63'd0, err}, 64'd1);
      synch_en = 1'b1;
      send({$urandom, $urandom}, 1'b1, 1'b0);
      @(negedge clk);
      check("t4_err_clear", {63'd0, err}, 64'd0);
      wait_out(400, lat);
      check("t4_latency", 64'(lat), 64'd176);

      // Output back-pressure
      @(posedge clk); #1 out_ready = 1'b0;
      send({$urandom, $urandom}, 1'b1, 1'b0);
      wait_out(400, lat);
      snap0 = out_s0; snap1 = out_s1; snap2 = out_s2;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t5_hold", {62'd0, out_valid, in_ready} | (out_s0 ^ snap0) | (out_s1 ^ snap1) | (out_s2 ^ snap2),
               64'b10);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1;
      check("t5_bufs_zero", dut.buf_s0 | dut.buf_s1 | dut.buf_s2, 64'd0);
      check("t5_fresh_zero", 64'(dut.fresh_q), 64'd0);
      check("t5_released", {62'd0, out_valid, in_ready}, 64'b01);

      // Asynchronous reset during WAIT of nibble 5
      send({$urandom, $urandom}, 1'b1, 1'b0);
      n = 0;
      while (n < 6) begin
         @(negedge clk);
         if (fresh_ready) n++;
      end
      @(posedge clk);
      @(posedge clk);
      #3;
      check("t6_in_wait", {63'd0, sb_rst}, 64'd0);
      rst = 1'b0;
      #1;
      check("t6_rst_ctrl", {59'd0, in_ready, out_valid, fresh_ready, err, sb_rst}, 64'b00001);
      check("t6_rst_sbox", {1'b0, sb_x_s0, sb_x_s1, sb_x_s2, sb_fresh}, 64'd0);
      check("t6_rst_bufs", dut.buf_s0 | dut.buf_s1 | dut.buf_s2 | out_s0 | out_s1 | out_s2, 64'd0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      d = {$urandom, $urandom};
      send(d, 1'b1, 1'b0);
      wait_out(400, lat);
      check("t6_latency", 64'(lat), 64'd176);
      @(posedge clk); #1;
      check("t6_value", last_out, sbox_layer(d));
      check("sb_empty", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
